dev_bridge_ic: RTL



---
 rtl/dev_bridge_ic.sv | 112 +++++++++++
 1 files changed

// File: rtl/dev_bridge_ic.sv
// Processor-bus bridge to NUM_DEV memory-mapped devices with an
// integrated maskable level/edge interrupt controller and error flag.
module dev_bridge_ic #(
   parameter int          NUM_DEV  = 3,
   parameter logic [31:0] DEV_BASE = 32'h0000_7F00
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [31:2]            PrAddr,
   input  logic [3:0]             BE,
   input  logic [31:0]            PrWD,
   input  logic                   PrWe,
   output logic [31:0]            PrRD,
   output logic [7:2]             HWInt,
   output logic [3:2]             DEV_Addr,
   output logic [31:0]            DEV_WD,
   output logic [3:0]             DEV_BE,
   output logic [NUM_DEV-1:0]     DEV_we,
   input  logic [32*NUM_DEV-1:0]  DEV_RD,
   input  logic [NUM_DEV-1:0]     DEV_IRQ
);

   logic               blk_hit;
   logic [3:0]         win;
   logic [1:0]         rsel;
   logic [NUM_DEV-1:0] hit;
   logic               ic_hit;
   logic               miss;

   logic [NUM_DEV-1:0] pend, mask, mode, irq_q;
   logic [NUM_DEV-1:0] pend_nxt, rise, clr_bits;
   logic               err;

   logic               ic_we;
   logic               mask_we, mode_we, clr_we, err_clr;
   logic [31:0]        rd_dev, rd_ic;
   logic               unused_bits;

   // Base is 256-byte aligned, so DEV_BASE[31:4]+i is the block with nibble i.
   assign blk_hit = PrAddr[31:8] == DEV_BASE[31:8];
   assign win     = PrAddr[7:4];
   assign rsel    = PrAddr[3:2];
   assign ic_hit  = blk_hit && (win == 4'hF);

   always_comb begin
      hit = '0;
      for (int i = 0; i < NUM_DEV; i++)
         hit[i] = blk_hit && (win == 4'(i));
   end

   assign miss = blk_hit && !(|hit) && !ic_hit;

   assign DEV_Addr = PrAddr[3:2];
   assign DEV_WD   = PrWD;
   assign DEV_BE   = BE;
   assign DEV_we   = rst ? '0 : (hit & {NUM_DEV{PrWe}});

   assign ic_we   = PrWe && ic_hit;
   assign mask_we = ic_we && (rsel == 2'd1) && BE[0];
   assign mode_we = ic_we && (rsel == 2'd2) && BE[0];
   assign clr_we  = ic_we && (rsel == 2'd3) && BE[0];
   assign err_clr = ic_we && (rsel == 2'd3) && BE[3] && PrWD[31];

   assign clr_bits = clr_we ? PrWD[NUM_DEV-1:0] : '0;
   assign rise     = DEV_IRQ & ~irq_q;

   // Edge channels latch rises (set beats clear); level channels track the line.
   assign pend_nxt = (mode & (rise | (pend & ~clr_bits)))
                   | (~mode & DEV_IRQ);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pend  <= '0;
         mask  <= '0;
         mode  <= '0;
         irq_q <= '0;
         err   <= 1'b0;
      end else begin
         pend  <= pend_nxt;
         irq_q <= DEV_IRQ;
         err   <= miss || (err && !err_clr);
         if (mask_we)
            mask <= PrWD[NUM_DEV-1:0];
         if (mode_we)
            mode <= PrWD[NUM_DEV-1:0];
      end
   end

   always_comb begin
      rd_dev = '0;
      for (int i = 0; i < NUM_DEV; i++)
         if (hit[i])
            rd_dev = rd_dev | DEV_RD[32*i +: 32];
   end

   always_comb begin
      rd_ic = '0;
      case (rsel)
         2'd0: rd_ic = 32'(pend);
         2'd1: rd_ic = 32'(mask);
         2'd2: rd_ic = 32'(mode);
         2'd3: rd_ic = {err, 23'b0, 8'(DEV_IRQ)};
         default: rd_ic = '0;
      endcase
   end

   assign PrRD  = ic_hit ? rd_ic : rd_dev;
   assign HWInt = 6'(pend & mask);

   assign unused_bits = ^{PrWD, BE};

endmodule
